// File: rtl/pong_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg : shared screen geometry and paddle motion encoding for Pong.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

endpackage

`default_nettype wire

// File: rtl/paddle_ai_dir.sv
// ----------------------------------------------------------------------------
// paddle_ai_dir : combinational ball-tracking request with a dead band
//                 around the paddle centre.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module paddle_ai_dir
    import pong_pkg::*;
#(
    parameter int PADDLE_H    = 200,
    parameter int AI_DEADZONE = 4
) (
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_ball_y,
    output logic [1:0]         o_req
);

    localparam logic [COORD_W:0] c_half_h   = (COORD_W+1)'(PADDLE_H / 2);
    localparam logic [COORD_W:0] c_deadzone = (COORD_W+1)'(AI_DEADZONE);

    // One extra bit so centre and dead-band sums never wrap.
    logic [COORD_W:0] w_ctr;
    logic [COORD_W:0] w_ball_plus_dz;
    logic [COORD_W:0] w_ctr_plus_dz;

    assign w_ctr          = {1'b0, i_y} + c_half_h;
    assign w_ball_plus_dz = {1'b0, i_ball_y} + c_deadzone;
    assign w_ctr_plus_dz  = w_ctr + c_deadzone;

    always_comb begin
        o_req = DIR_IDLE;
        if (w_ball_plus_dz < w_ctr) begin
            o_req = DIR_UP;
        end else if ({1'b0, i_ball_y} > w_ctr_plus_dz) begin
            o_req = DIR_DOWN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/paddle_ctrl.sv
// ----------------------------------------------------------------------------
// paddle_ctrl : one player's paddle position with manual/AI modes, speed
//               ramp while a direction is held, and bounded travel.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int POS_X        = 20,
    parameter int POS_Y        = 200,
    parameter int PADDLE_H     = 200,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 280,
    parameter int SPEED_MAX    = 4,
    parameter int AI_SPEED_MAX = 2,
    parameter int ACCEL_TICKS  = 8,
    parameter int AI_DEADZONE  = 4
) (
    input  logic               game_clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               mode,
    input  logic               freeze,
    input  logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [1:0]         dir,
    output logic [3:0]         speed
);

    localparam int            HOLD_W     = $clog2(ACCEL_TICKS + 1);
    localparam logic [3:0]    c_spd_max  = 4'(SPEED_MAX);
    localparam logic [3:0]    c_ai_max   = 4'(AI_SPEED_MAX);
    localparam logic [11:0]   c_y_min    = 12'(Y_MIN);
    localparam logic [11:0]   c_y_max    = 12'(Y_MAX);
    localparam logic [HOLD_W-1:0] c_accel = HOLD_W'(ACCEL_TICKS);

    logic [COORD_W-1:0] r_y;
    logic [1:0]         r_dir;
    logic [3:0]         r_speed;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_mode_q;

    logic [1:0]         w_ai_req;
    logic [1:0]         w_req;
    logic [3:0]         w_cap;
    logic [3:0]         w_step;
    logic [3:0]         w_spd_inc;
    logic [3:0]         w_spd_start;
    logic [HOLD_W-1:0]  w_hold_inc;
    logic [11:0]        w_y_ext;
    logic [COORD_W-1:0] w_y_up;
    logic [COORD_W-1:0] w_y_down;
    logic [COORD_W-1:0] w_y_next;

    paddle_ai_dir #(
        .PADDLE_H    (PADDLE_H),
        .AI_DEADZONE (AI_DEADZONE)
    ) u_ai_dir (
        .i_y      (r_y),
        .i_ball_y (ball_y),
        .o_req    (w_ai_req)
    );

    assign w_req = mode ? w_ai_req
                 : up   ? DIR_UP
                 : down ? DIR_DOWN
                 :        DIR_IDLE;

    assign w_cap       = mode ? c_ai_max : c_spd_max;
    assign w_step      = (w_req != r_dir) ? 4'd1 : r_speed;
    assign w_spd_inc   = (r_speed < w_cap) ? r_speed + 4'd1 : w_cap;
    assign w_spd_start = (w_cap < 4'd2) ? w_cap : 4'd2;
    assign w_hold_inc  = r_hold_cnt + HOLD_W'(1);

    // Clamp tests are done in 12 bits so neither direction can wrap.
    assign w_y_ext  = {2'b00, r_y};
    assign w_y_up   = (w_y_ext < c_y_min + {8'd0, w_step}) ? COORD_W'(Y_MIN)
                    : r_y - {6'd0, w_step};
    assign w_y_down = (w_y_ext + {8'd0, w_step} > c_y_max) ? COORD_W'(Y_MAX)
                    : r_y + {6'd0, w_step};
    assign w_y_next = (w_req == DIR_UP) ? w_y_up : w_y_down;

    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            r_y        <= COORD_W'(POS_Y);
            r_dir      <= DIR_IDLE;
            r_speed    <= 4'd1;
            r_hold_cnt <= '0;
            r_mode_q   <= 1'b0;
        end else if (freeze || (mode != r_mode_q) || (w_req == DIR_IDLE)) begin
            r_dir      <= DIR_IDLE;
            r_speed    <= 4'd1;
            r_hold_cnt <= '0;
            r_mode_q   <= freeze ? r_mode_q : mode;
        end else if (w_req != r_dir) begin
            r_y   <= w_y_next;
            r_dir <= w_req;
            if (ACCEL_TICKS == 1) begin
                r_speed    <= w_spd_start;
                r_hold_cnt <= '0;
            end else begin
                r_speed    <= 4'd1;
                r_hold_cnt <= HOLD_W'(1);
            end
        end else begin
            r_y <= w_y_next;
            if (w_hold_inc == c_accel) begin
                r_hold_cnt <= '0;
                r_speed    <= w_spd_inc;
            end else begin
                r_hold_cnt <= w_hold_inc;
            end
        end
    end

    assign x     = COORD_W'(POS_X);
    assign y     = r_y;
    assign dir   = r_dir;
    assign speed = r_speed;

endmodule

`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_paddle_ctrl : directed and randomized checks of paddle_ctrl against a
//                  run-length reference model.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_paddle_ctrl;

    localparam int P_POS_X  = 20;
    localparam int P_POS_Y  = 200;
    localparam int P_HALF_H = 100;
    localparam int P_Y_MIN  = 0;
    localparam int P_Y_MAX  = 280;
    localparam int P_SPD    = 4;
    localparam int P_AI_SPD = 2;
    localparam int P_ACCEL  = 8;
    localparam int P_DZ     = 4;

    logic       game_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       up       = 1'b0;
    logic       down     = 1'b0;
    logic       mode     = 1'b0;
    logic       freeze   = 1'b0;
    logic [9:0] ball_y   = 10'd0;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
    logic [3:0] speed;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: position, direction, count of consecutive moves, mode seen.
    int m_y, m_dir, m_run, m_mode_q, m_cap;

    paddle_ctrl u_dut (
        .game_clk (game_clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .mode     (mode),
        .freeze   (freeze),
        .ball_y   (ball_y),
        .x        (x),
        .y        (y),
        .dir      (dir),
        .speed    (speed)
    );

    always #5 game_clk = ~game_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_y      = P_POS_Y;
        m_dir    = 0;
        m_run    = 0;
        m_mode_q = 0;
        m_cap    = P_SPD;
    endfunction

    function automatic void model_step();
        int req, ctr, step;
        m_cap = mode ? P_AI_SPD : P_SPD;
        if (mode) begin
            ctr = m_y + P_HALF_H;
            if (int'(ball_y) + P_DZ < ctr)      req = 1;
            else if (int'(ball_y) > ctr + P_DZ) req = 2;
            else                                req = 0;
        end else begin
            req = up ? 1 : (down ? 2 : 0);
        end
        if (freeze) begin
            m_dir = 0; m_run = 0;
        end else if (int'(mode) != m_mode_q) begin
            m_dir = 0; m_run = 0; m_mode_q = int'(mode);
        end else if (req == 0) begin
            m_dir = 0; m_run = 0;
        end else begin
            if (req != m_dir) m_run = 0;
            m_run++;
            step = imin(1 + (m_run - 1) / P_ACCEL, m_cap);
            if (req == 1) m_y = (m_y - step < P_Y_MIN) ? P_Y_MIN : m_y - step;
            else          m_y = (m_y + step > P_Y_MAX) ? P_Y_MAX : m_y + step;
            m_dir = req;
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".x"},     32'(x),     P_POS_X);
        chk({tag, ".y"},     32'(y),     m_y);
        chk({tag, ".dir"},   32'(dir),   m_dir);
        chk({tag, ".speed"}, 32'(speed), imin(1 + m_run / P_ACCEL, m_cap));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge game_clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Called at posedge+1; raises reset between edges and checks it acts at once.
    task automatic rst_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        int len;
        model_reset();
        #12 rst = 1'b0;
        check_outputs("reset");
        ticks("idle", 10);

        up = 1'b1;
        ticks("up_ramp", 24);
        chk("up24.y", 32'(y), 152);
        chk("up24.speed", 32'(speed), 4);
        ticks("up_clamp", 38);
        chk("top_clamp.y", 32'(y), P_Y_MIN);

        up = 1'b0; down = 1'b1;
        ticks("down3", 3);
        up = 1'b1;
        ticks("both", 2);
        chk("reversal.dir", 32'(dir), 1);
        up = 1'b0;
        ticks("down_long", 100);
        chk("bottom_clamp.y", 32'(y), P_Y_MAX);

        down = 1'b0; up = 1'b1;
        ticks("pre_rst", 12);
        rst_pulse("rst_mid");
        ticks("post_rst", 12);
        up = 1'b0;
        rst_pulse("rst_idle");

        mode = 1'b1; ball_y = 10'd50;
        tick("ai_switch");
        chk("ai_switch.y", 32'(y), P_POS_Y);
        ticks("ai_up", 20);
        chk("ai_cap.speed", 32'(speed), P_AI_SPD);
        ball_y = 10'd302;
        ticks("ai_track", 80);
        chk("ai_settle.dir", 32'(dir), 0);

        mode = 1'b0; ball_y = 10'd0;
        rst_pulse("rst_pre_freeze");
        down = 1'b1;
        ticks("frz_ramp", 18);
        chk("frz_ramp.speed", 32'(speed), 3);
        freeze = 1'b1;
        ticks("frozen", 2);
        freeze = 1'b0;
        ticks("unfrozen", 2);

        for (int s = 0; s < 150; s++) begin
            up     = 1'($urandom_range(0, 1));
            down   = 1'($urandom_range(0, 1));
            freeze = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) mode = ~mode;
            ball_y = 10'($urandom_range(0, 1023));
            len    = $urandom_range(1, 30);
            ticks("rand", len);
            if ($urandom_range(0, 19) == 0) rst_pulse("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
